// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART byte transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } state_e;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk, input int baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-cell timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of a cell.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_end_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte serializer with one-cycle done pulse for sequencer pacing.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data,
    output logic       uart_txd,
    output logic       uart_tx_done,
    output logic       uart_tx_busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       txd_q, txd_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       cnt_clr, cnt_en, bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i    (clk_50m),
        .rst_ni   (rst_n),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .bit_end_o(bit_end)
    );

    // Line level is registered together with the state change so the pin
    // never glitches and each level lasts exactly one bit cell.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (uart_tx_en) begin
                    shift_d = uart_tx_data;
                    busy_d  = 1'b1;
                    cnt_clr = 1'b1;
                    txd_d   = 1'b0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^uart_tx_data;
`endif
                end
            end
            START: begin
                cnt_en = 1'b1;
                if (bit_end) begin
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_en = 1'b1;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = par_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_en = 1'b1;
                if (bit_end) begin
                    txd_d   = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                cnt_en = 1'b1;
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = GAP;
                end
            end
            // Sequencer swaps its byte on the edge it sees done, so IDLE
            // must wait one cycle before sampling again.
            GAP: begin
                busy_d  = 1'b0;
                txd_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign uart_txd     = txd_q;
    assign uart_tx_done = done_q;
    assign uart_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed self-checking bench for uart_byte_tx.
module tb_uart_byte_tx;

    localparam int CPB = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_txd;
    logic       uart_tx_done;
    logic       uart_tx_busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_byte_tx dut (
        .clk_50m     (clk),
        .rst_n       (rst_n),
        .uart_tx_en  (uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .uart_txd    (uart_txd),
        .uart_tx_done(uart_tx_done),
        .uart_tx_busy(uart_tx_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller sits 1 ns after an edge with the DUT idle. Cycle k is the
    // sample taken 1 ns after the (k-1)th edge following the start edge.
    task automatic send_check(input string tag, input logic [7:0] d,
                              input int drop_at);
        logic [10:0] fb;
        int dn, dk, c;
        fb = '1;
        fb[0] = 1'b0;
        fb[8:1] = d;
`ifdef UART_TX_PARITY_EN
        fb[9] = ^d;
`endif
        dn = 0;
        dk = 0;
        uart_tx_data = d;
        uart_tx_en = 1'b1;
        tick(1);
        chk({tag, "_busy_start"}, uart_tx_busy, 1'b1);
        for (int k = 1; k <= NB * CPB + 2; k++) begin
            if (k == drop_at) begin
                uart_tx_en = 1'b0;
                uart_tx_data = 8'hFF;
            end
            if (uart_tx_done === 1'b1) begin
                dn++;
                dk = k;
            end
            if (k <= NB * CPB) begin
                c = (k - 1) / CPB;
                if ((k - 1) % CPB == 0 || (k - 1) % CPB == CPB - 1)
                    chk($sformatf("%s_bit%0d_k%0d", tag, c, k),
                        uart_txd, fb[c]);
            end
            if (k == NB * CPB + 1)
                chk({tag, "_busy_gap"}, uart_tx_busy, 1'b1);
            if (k == NB * CPB + 2) begin
                chk({tag, "_busy_idle"}, uart_tx_busy, 1'b0);
                chk({tag, "_txd_idle"}, uart_txd, 1'b1);
            end
            if (k < NB * CPB + 2) tick(1);
        end
        chk({tag, "_done_cnt"}, dn, 1);
        chk({tag, "_done_cyc"}, dk, NB * CPB + 1);
    endtask

    initial begin
        logic [7:0] seq_b [4];
        logic [7:0] rx;
        int bad, dn;

        seq_b[0] = 8'h12;
        seq_b[1] = 8'h34;
        seq_b[2] = 8'h56;
        seq_b[3] = 8'h78;

        rst_n = 1'b0;
        uart_tx_en = 1'b0;
        uart_tx_data = 8'h00;
        tick(3);
        chk("rst_txd", uart_txd, 1'b1);
        chk("rst_done", uart_tx_done, 1'b0);
        chk("rst_busy", uart_tx_busy, 1'b0);
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            tick(1);
            if (uart_txd !== 1'b1 || uart_tx_done !== 1'b0
                || uart_tx_busy !== 1'b0)
                bad++;
        end
        chk("idle_10000", bad, 0);

        send_check("a5", 8'hA5, 1);
        tick(3);
        send_check("07", 8'h07, 1);
        tick(3);

        // Sequencer emulation: en held, byte replaced the edge after done.
        uart_tx_data = seq_b[0];
        uart_tx_en = 1'b1;
        tick(1);
        chk("seq0_start", uart_txd, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(CPB / 2 - 1);
            chk($sformatf("seq%0d_mid_start", i), uart_txd, 1'b0);
            rx = '0;
            for (int b = 0; b < 8; b++) begin
                tick(CPB);
                rx[b] = uart_txd;
            end
            chk($sformatf("seq%0d_byte", i), rx, seq_b[i]);
`ifdef UART_TX_PARITY_EN
            tick(CPB);
            chk($sformatf("seq%0d_par", i), uart_txd, ^seq_b[i]);
`endif
            tick(CPB);
            chk($sformatf("seq%0d_stop", i), uart_txd, 1'b1);
            for (int w = 0; w < 2 * CPB && uart_tx_done !== 1'b1; w++)
                tick(1);
            chk($sformatf("seq%0d_done", i), uart_tx_done, 1'b1);
            tick(1);
            if (i < 3) uart_tx_data = seq_b[i+1];
            else uart_tx_en = 1'b0;
            chk($sformatf("seq%0d_gap", i), uart_txd, 1'b1);
            chk($sformatf("seq%0d_gap_done", i), uart_tx_done, 1'b0);
            if (i < 3) begin
                tick(1);
                chk($sformatf("seq%0d_next_start", i), uart_txd, 1'b0);
            end
        end
        tick(2);
        chk("seq_end_txd", uart_txd, 1'b1);
        chk("seq_end_busy", uart_tx_busy, 1'b0);
        tick(3);

        send_check("mid", 8'h00, 2000);
        tick(3);

        // Asynchronous reset mid-frame while a 0 data bit is on the line.
        uart_tx_data = 8'hC3;
        uart_tx_en = 1'b1;
        tick(1);
        uart_tx_en = 1'b0;
        tick(1499);
        chk("rst_mid_pre", uart_txd, 1'b0);
        #5;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_txd", uart_txd, 1'b1);
        chk("rst_mid_busy", uart_tx_busy, 1'b0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (uart_tx_done === 1'b1) dn++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (uart_tx_done === 1'b1) dn++;
        end
        chk("rst_mid_no_done", dn, 0);
        chk("rst_mid_idle", uart_txd, 1'b1);
        send_check("3c", 8'h3C, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
